// File: rtl/status_flag_controller_pkg.sv
// Shared definitions for the NZCV status flag controller: ARM condition codes,
// flag bit positions inside the packed {Z,C,N,V} word, and occupancy states.
package status_flag_controller_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  // Occupancy of the in-flight flag-writer counter; decoded, never stored.
  typedef enum logic [1:0] {
    OCC_IDLE = 2'd0,
    OCC_BUSY = 2'd1,
    OCC_FULL = 2'd2
  } occ_e;

endpackage

// File: rtl/status_flag_controller_if.sv
// ID / WB-side signal bundle of the status flag controller.
// master = pipeline side driving ID and WB, slave = the controller.
interface status_flag_controller_if;

  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_set_flags;
  logic       flush;
  logic       wb_flag_we;
  logic [3:0] wb_flags;
  logic       stall;
  logic       issue;
  logic       exec;
  logic [3:0] status_reg;
  logic [2:0] pending;
  logic       protocol_err;

  modport master (
    output id_valid, id_cond, id_set_flags, flush, wb_flag_we, wb_flags,
    input  stall, issue, exec, status_reg, pending, protocol_err
  );

  modport slave (
    input  id_valid, id_cond, id_set_flags, flush, wb_flag_we, wb_flags,
    output stall, issue, exec, status_reg, pending, protocol_err
  );

endinterface

// File: rtl/status_flag_controller_cond_eval.sv
// Combinational ARM condition evaluator: condition field + {Z,C,N,V} -> pass.
import status_flag_controller_pkg::*;

module status_flag_controller_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, c, n, v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // NOTE: assign a default before the case so no path leaves pass unassigned (no latch).
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_flag_controller.sv
// Architectural NZCV register plus in-flight flag-writer tracking; stalls ID
// until the flags a conditional instruction reads are final, with WB bypass.
import status_flag_controller_pkg::*;

module status_flag_controller #(
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  status_flag_controller_if.slave  bus
);

  localparam logic [2:0] PEND_MAX = 3'(MAX_PENDING);

  logic [3:0] status_q, status_d;
  logic [2:0] pending_q, pending_d;
  logic       err_q, err_d;

  occ_e       occ;
  logic       wb_last;
  logic       flags_final;
  logic [3:0] eff_flags;
  logic       cond_pass;
  logic       is_cond;
  logic       cond_hazard;
  logic       full_hazard;
  logic       stall;
  logic       issue;
  logic       exec;
  logic       accepted;
  logic       retire;
  logic       stray;

  always_comb begin
    occ = OCC_IDLE;
    if (pending_q == PEND_MAX)   occ = OCC_FULL;
    else if (pending_q != 3'd0)  occ = OCC_BUSY;
  end

  // The last outstanding writer retiring this cycle makes its flags usable now.
  assign wb_last     = bus.wb_flag_we && (pending_q == 3'd1);
  assign flags_final = (occ == OCC_IDLE) || wb_last;
  assign eff_flags   = wb_last ? bus.wb_flags : status_q;

  status_flag_controller_cond_eval u_cond_eval (
    .cond  (bus.id_cond),
    .flags (eff_flags),
    .pass  (cond_pass)
  );

  assign is_cond     = (bus.id_cond != COND_AL);
  assign cond_hazard = is_cond && !flags_final;
  assign full_hazard = bus.id_set_flags && (occ == OCC_FULL) && !bus.wb_flag_we;

  assign stall    = bus.id_valid && !bus.flush && (cond_hazard || full_hazard);
  assign issue    = bus.id_valid && !stall && !bus.flush;
  assign exec     = issue && cond_pass;
  assign accepted = exec && bus.id_set_flags;

  assign retire = bus.wb_flag_we && (pending_q != 3'd0);
  assign stray  = bus.wb_flag_we && (pending_q == 3'd0);

  always_comb begin
    pending_d = pending_q + {2'b00, accepted} - {2'b00, retire};
    status_d  = status_q;
    err_d     = err_q;
    if (retire) status_d = bus.wb_flags;
    if (stray)  err_d    = 1'b1;
  end

  // NOTE: reset is sampled on the clock edge (synchronous); state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q  <= 4'b0000;
      pending_q <= 3'd0;
      err_q     <= 1'b0;
    end else begin
      status_q  <= status_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.issue        = issue;
  assign bus.exec         = exec;
  assign bus.status_reg   = status_q;
  assign bus.pending      = pending_q;
  assign bus.protocol_err = err_q;

endmodule
